// File: rtl/mem_port_sequencer.sv
// -----------------------------------------------------------------------------
// mem_port_sequencer
//
// Arbitrates one single-port synchronous RAM between the core data port and
// the UART loader.  Loads are read, extended and returned; word stores
// (core SW and all loader writes) are written directly; byte and halfword
// stores do a read-modify-write so that untouched lanes survive.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   core_req/ldst/addr/wdata   core request (held until core_ack)
//   core_ack, core_rdata       one-cycle completion pulse, extended load data
//   uart_req/addr/wdata        loader word write (held until uart_ack)
//   uart_ack                   one-cycle completion pulse
//   mem_addr/wdata/we, mem_rdata  RAM port (read data one cycle after addr)
//   busy                       high whenever the sequencer is not idle
//
// Handshake: a requester raises req with stable payload and keeps it until it
// samples its ack high on a rising edge; ack is high for exactly one cycle.
// If req is still high on the edge after the ack cycle's successor it is
// treated as a fresh request.
//
// Flow:  load     IDLE -> RD -> RDW -> IDLE   (ack in RDW)
//        SW/uart  IDLE -> WR -> IDLE          (ack in WR)
//        SH/SB    IDLE -> RD -> MRG -> IDLE   (ack in MRG)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef MEM_PORT_SEQ_OPS
`define MEM_PORT_SEQ_OPS
`define LDST_WID 3
`define LW_OP  3'd0
`define LH_OP  3'd1
`define LHU_OP 3'd2
`define LB_OP  3'd3
`define LBU_OP 3'd4
`define SW_OP  3'd5
`define SH_OP  3'd6
`define SB_OP  3'd7
`endif

module mem_port_sequencer (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 core_req,
  input  logic [`LDST_WID-1:0] core_ldst,
  input  logic [31:0]          core_addr,
  input  logic [31:0]          core_wdata,
  output logic                 core_ack,
  output logic [31:0]          core_rdata,
  input  logic                 uart_req,
  input  logic [31:0]          uart_addr,
  input  logic [31:0]          uart_wdata,
  output logic                 uart_ack,
  output logic [13:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_we,
  input  logic [31:0]          mem_rdata,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RDW  = 3'd2,
    S_MRG  = 3'd3,
    S_WR   = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_grant_uart;
  logic [15:0]          r_addr;
  logic [`LDST_WID-1:0] r_op;
  logic [31:0]          r_wdata;
  logic [31:0]          r_core_rdata;

  logic                 w_is_load;
  logic [15:0]          w_half;
  logic [7:0]           w_byte;
  logic [31:0]          w_ext;
  logic [31:0]          w_merged;
  // Only addr[15:0] reaches the RAM; the upper bits are decoded upstream.
  logic                 w_unused_addr_hi;

  assign w_unused_addr_hi = ^{core_addr[31:16], uart_addr[31:16]};

  assign w_is_load = (r_op == `LW_OP) || (r_op == `LH_OP) || (r_op == `LHU_OP) ||
                     (r_op == `LB_OP) || (r_op == `LBU_OP);

  // Lane extraction from the word just read.
  assign w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_addr[1:0])
      2'b00:   w_byte = mem_rdata[7:0];
      2'b01:   w_byte = mem_rdata[15:8];
      2'b10:   w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
  end

  always_comb begin
    w_ext = mem_rdata;
    case (r_op)
      `LH_OP:  w_ext = {{16{w_half[15]}}, w_half};
      `LHU_OP: w_ext = {16'h0000, w_half};
      `LB_OP:  w_ext = {{24{w_byte[7]}}, w_byte};
      `LBU_OP: w_ext = {24'h000000, w_byte};
      default: w_ext = mem_rdata;
    endcase
  end

  // New byte/halfword dropped into its lane; all other lanes come from RAM.
  always_comb begin
    w_merged = mem_rdata;
    if (r_op == `SH_OP) begin
      if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
      else           w_merged[15:0]  = r_wdata[15:0];
    end else begin
      case (r_addr[1:0])
        2'b00:   w_merged[7:0]   = r_wdata[7:0];
        2'b01:   w_merged[15:8]  = r_wdata[7:0];
        2'b10:   w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_grant_uart <= 1'b0;
      r_addr       <= 16'h0000;
      r_op         <= `LW_OP;
      r_wdata      <= 32'h0;
      r_core_rdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (uart_req) begin
            r_grant_uart <= 1'b1;
            r_addr       <= uart_addr[15:0];
            r_op         <= `SW_OP;
            r_wdata      <= uart_wdata;
            r_state      <= S_WR;
          end else if (core_req) begin
            r_grant_uart <= 1'b0;
            r_addr       <= core_addr[15:0];
            r_op         <= core_ldst;
            r_wdata      <= core_wdata;
            r_state      <= (core_ldst == `SW_OP) ? S_WR : S_RD;
          end
        end
        S_RD:  r_state <= w_is_load ? S_RDW : S_MRG;
        S_RDW: begin
          r_core_rdata <= w_ext;
          r_state      <= S_IDLE;
        end
        S_MRG, S_WR: begin
          r_grant_uart <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are pure decodes of the state register, so an asynchronous reset
  // in RD or MRG drops mem_we immediately and no partial write reaches RAM.
  assign busy      = (r_state != S_IDLE);
  assign mem_we    = (r_state == S_WR) || (r_state == S_MRG);
  assign uart_ack  = (r_state == S_WR) && r_grant_uart;
  assign core_ack  = (r_state == S_RDW) || (r_state == S_MRG) ||
                     ((r_state == S_WR) && !r_grant_uart);
  assign mem_addr  = r_addr[15:2];
  // In MRG the RAM word is only valid during the cycle itself, so the merge
  // feeds the write port combinationally.
  assign mem_wdata = (r_state == S_MRG) ? w_merged : r_wdata;
  // Load data is forwarded in its ack cycle and then held until the next load.
  assign core_rdata = (r_state == S_RDW) ? w_ext : r_core_rdata;

endmodule

// File: tb/tb_mem_port_sequencer.sv
`timescale 1ns/1ps

`ifndef MEM_PORT_SEQ_OPS
`define MEM_PORT_SEQ_OPS
`define LDST_WID 3
`define LW_OP  3'd0
`define LH_OP  3'd1
`define LHU_OP 3'd2
`define LB_OP  3'd3
`define LBU_OP 3'd4
`define SW_OP  3'd5
`define SH_OP  3'd6
`define SB_OP  3'd7
`endif

module tb_mem_port_sequencer;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 core_req;
  logic [`LDST_WID-1:0] core_ldst;
  logic [31:0]          core_addr;
  logic [31:0]          core_wdata;
  logic                 core_ack;
  logic [31:0]          core_rdata;
  logic                 uart_req;
  logic [31:0]          uart_addr;
  logic [31:0]          uart_wdata;
  logic                 uart_ack;
  logic [13:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic                 mem_we;
  logic [31:0]          mem_rdata;
  logic                 busy;

  always #5 clk = ~clk;

  mem_port_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_ldst(core_ldst), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
    .uart_req(uart_req), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_ack(uart_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // ---------------- RAM model and write monitor ----------------
  logic [31:0] ram [0:16383];
  int          we_cnt = 0;
  logic [31:0] last_wd = 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      we_cnt  <= we_cnt + 1;
      last_wd <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed load data %h with empty expected queue", tag, core_rdata);
    end else begin
      e = exp_q.pop_front();
      chk(tag, core_rdata, e);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_core_ack"},  32'(core_ack), 32'h0);
    chk({tag, "_uart_ack"},  32'(uart_ack), 32'h0);
    chk({tag, "_mem_we"},    32'(mem_we), 32'h0);
    chk({tag, "_busy"},      32'(busy), 32'h0);
    chk({tag, "_mem_addr"},  32'(mem_addr), 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_core_rdata"}, core_rdata, 32'h0);
  endtask

  function automatic logic is_load_op(input logic [`LDST_WID-1:0] op);
    return (op == `LW_OP) || (op == `LH_OP) || (op == `LHU_OP) ||
           (op == `LB_OP) || (op == `LBU_OP);
  endfunction

  // ---------------- driver tasks ----------------
  // Single core access from an idle DUT; latency counted in negedges from the
  // drive point, so the accept edge is the first posedge after driving.
  task automatic core_op(input string tag, input logic [`LDST_WID-1:0] op,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input int exp_lat, input int exp_we);
    int n;
    bit ok;
    int we0;
    @(negedge clk);
    chk({tag, "_idle_before"}, 32'(busy), 32'h0);
    we0 = we_cnt;
    if (is_load_op(op)) exp_q.push_back(exp_rd);
    core_ldst = op; core_addr = addr; core_wdata = wd; core_req = 1'b1;
    n = 0; ok = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      if (core_ack) ok = 1;
    end
    chk({tag, "_ack_seen"}, 32'(ok), 32'h1);
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    if (ok && is_load_op(op)) sb_pop({tag, "_rdata"});
    core_req = 1'b0;
    @(negedge clk);
    chk({tag, "_we_cycles"}, 32'(we_cnt - we0), 32'(exp_we));
  endtask

  task automatic uart_op(input string tag, input logic [31:0] addr, input logic [31:0] wd);
    int n;
    bit ok;
    int we0;
    @(negedge clk);
    we0 = we_cnt;
    uart_addr = addr; uart_wdata = wd; uart_req = 1'b1;
    n = 0; ok = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      if (uart_ack) ok = 1;
    end
    chk({tag, "_ack_seen"}, 32'(ok), 32'h1);
    chk({tag, "_latency"}, 32'(n), 32'h1);
    uart_req = 1'b0;
    @(negedge clk);
    chk({tag, "_we_cycles"}, 32'(we_cnt - we0), 32'h1);
    chk({tag, "_we_data"}, last_wd, wd);
  endtask

  // ---------------- directed sequence ----------------
  logic [`LDST_WID-1:0] b2b_op   [3];
  logic [31:0]          b2b_addr [3];
  logic [31:0]          b2b_wd   [3];
  logic [31:0]          b2b_exp  [3];

  initial begin
    int n, n_u, idle_seen, we0;
    bit ok, ok_u;
    logic [31:0] model_w;
    logic [7:0]  bval;
    int          lane;

    rst_n = 1'b0;
    core_req = 1'b0; core_ldst = `LW_OP; core_addr = 32'h0; core_wdata = 32'h0;
    uart_req = 1'b0; uart_addr = 32'h0; uart_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Preload and basic loads with every extension mode
    uart_op("preload", 32'h10, 32'h8899AABB);
    core_op("lw",  `LW_OP,  32'h10, 32'h0, 32'h8899AABB, 2, 0);
    core_op("lb",  `LB_OP,  32'h13, 32'h0, 32'hFFFFFF88, 2, 0);
    core_op("lbu", `LBU_OP, 32'h11, 32'h0, 32'h000000AA, 2, 0);
    core_op("lh",  `LH_OP,  32'h12, 32'h0, 32'hFFFF8899, 2, 0);
    core_op("lhu", `LHU_OP, 32'h11, 32'h0, 32'h0000AABB, 2, 0);

    // Byte RMW; core_rdata must not move on store completion
    core_op("sb", `SB_OP, 32'h12, 32'h55, 32'h0, 2, 1);
    chk("sb_we_data", last_wd, 32'h8855AABB);
    chk("sb_rdata_held", core_rdata, 32'h0000AABB);
    core_op("lw_after_sb", `LW_OP, 32'h10, 32'h0, 32'h8855AABB, 2, 0);

    // Simultaneous requests: loader wins, core follows after an idle cycle
    @(negedge clk);
    core_ldst = `SW_OP; core_addr = 32'h20; core_wdata = 32'hCAFEF00D; core_req = 1'b1;
    uart_addr = 32'h24; uart_wdata = 32'h12345678; uart_req = 1'b1;
    n = 0; ok = 0; ok_u = 0; n_u = 0;
    while (!ok && n < 30) begin
      @(negedge clk);
      n++;
      if (uart_ack && !ok_u) begin
        ok_u = 1; n_u = n;
        chk("sim_core_ack_with_uart", 32'(core_ack), 32'h0);
        uart_req = 1'b0;
      end
      if (core_ack) ok = 1;
    end
    chk("sim_uart_first", 32'(ok_u), 32'h1);
    chk("sim_core_ack_seen", 32'(ok), 32'h1);
    chk("sim_gap_ge2", 32'((n - n_u) >= 2), 32'h1);
    core_req = 1'b0;
    @(negedge clk);
    chk("sim_core_word", ram[8], 32'hCAFEF00D);
    chk("sim_uart_word", ram[9], 32'h12345678);

    // Reset during MRG of an SH: the write must never happen
    @(negedge clk);
    we0 = we_cnt;
    core_ldst = `SH_OP; core_addr = 32'h10; core_wdata = 32'h00007777; core_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mrg_reached", 32'(mem_we), 32'h1);
    rst_n = 1'b0;
    core_req = 1'b0;
    #1;
    chk_reset_outputs("mrg_reset");
    repeat (2) @(negedge clk);
    chk("mrg_reset_no_write", 32'(we_cnt - we0), 32'h0);
    chk("mrg_reset_ram", ram[4], 32'h8855AABB);
    rst_n = 1'b1;

    // Back-to-back with core_req held high across LW, LW, SW
    b2b_op[0] = `LW_OP; b2b_addr[0] = 32'h10; b2b_wd[0] = 32'h0;        b2b_exp[0] = 32'h8855AABB;
    b2b_op[1] = `LW_OP; b2b_addr[1] = 32'h24; b2b_wd[1] = 32'h0;        b2b_exp[1] = 32'h12345678;
    b2b_op[2] = `SW_OP; b2b_addr[2] = 32'h28; b2b_wd[2] = 32'hA5A5A5A5; b2b_exp[2] = 32'h0;
    @(negedge clk);
    core_ldst = b2b_op[0]; core_addr = b2b_addr[0]; core_wdata = b2b_wd[0]; core_req = 1'b1;
    exp_q.push_back(b2b_exp[0]);
    for (int k = 0; k < 3; k++) begin
      n = 0; ok = 0; idle_seen = 0;
      while (!ok && n < 20) begin
        @(negedge clk);
        n++;
        if (!busy) idle_seen++;
        if (core_ack) ok = 1;
      end
      chk($sformatf("b2b%0d_ack_seen", k), 32'(ok), 32'h1);
      chk($sformatf("b2b%0d_busy_at_ack", k), 32'(busy), 32'h1);
      if (k > 0) chk($sformatf("b2b%0d_idle_gap", k), 32'(idle_seen >= 1), 32'h1);
      if (ok && is_load_op(b2b_op[k])) sb_pop($sformatf("b2b%0d_rdata", k));
      if (k < 2) begin
        core_ldst = b2b_op[k+1]; core_addr = b2b_addr[k+1]; core_wdata = b2b_wd[k+1];
        if (is_load_op(b2b_op[k+1])) exp_q.push_back(b2b_exp[k+1]);
      end else begin
        core_req = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_idle_after", 32'(busy), 32'h0);
    chk("b2b_sw_word", ram[10], 32'hA5A5A5A5);

    // Halfword store into lane 1 (addr[0] ignored)
    core_op("sh_hi", `SH_OP, 32'h13, 32'h0000BEEF, 32'h0, 2, 1);
    core_op("lw_after_sh", `LW_OP, 32'h10, 32'h0, 32'hBEEFAABB, 2, 0);

    // Random byte stores against a reference word
    uart_op("rnd_init", 32'h30, 32'h0);
    model_w = 32'h0;
    for (int i = 0; i < 8; i++) begin
      lane = $urandom_range(0, 3);
      bval = 8'($urandom_range(0, 255));
      model_w[lane*8 +: 8] = bval;
      core_op($sformatf("rnd%0d_sb", i), `SB_OP, 32'h30 + 32'(lane), {24'h0, bval}, 32'h0, 2, 1);
      core_op($sformatf("rnd%0d_lb", i), `LB_OP, 32'h30 + 32'(lane), 32'h0,
              {{24{bval[7]}}, bval}, 2, 0);
      core_op($sformatf("rnd%0d_lw", i), `LW_OP, 32'h30, 32'h0, model_w, 2, 0);
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
